// File: rtl/skin_pkg.sv
// skin_pkg: shared widths, mask constant and FSM encoding for the skin bbox tracker
package skin_pkg;
  localparam int X_W = 11;
  localparam int Y_W = 10;
  localparam int CNT_W = 21;
  localparam int unsigned MIN_COUNT = 64;
  localparam logic [7:0] SKIN_ON = 8'd255;
  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    ACTIVE     = 2'd1,
    REPORT     = 2'd2
  } state_t;
endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: ce-qualified de falling-edge and vsync rising-edge pulses
module sync_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic ce,
  input  logic de,
  input  logic vsync,
  output logic de_fall,
  output logic vsync_rise
);
  logic de_q;
  logic vsync_q;
  // history only advances on enabled cycles so edges line up with sampled pixels
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      de_q <= 1'b0;
      vsync_q <= 1'b0;
    end else if (ce) begin
      de_q <= de;
      vsync_q <= vsync;
    end
  end
  assign de_fall = ce & ~de & de_q;
  assign vsync_rise = ce & vsync & ~vsync_q;
endmodule

// File: rtl/skin_bbox_tracker.sv
// skin_bbox_tracker: per-frame skin pixel count and bounding box from a binary mask stream
module skin_bbox_tracker #(
  parameter int X_W = skin_pkg::X_W,
  parameter int Y_W = skin_pkg::Y_W,
  parameter int CNT_W = skin_pkg::CNT_W,
  parameter int unsigned MIN_COUNT = skin_pkg::MIN_COUNT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic             de_in,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic [7:0]       skin_in,
  output logic [X_W-1:0]   x_min,
  output logic [X_W-1:0]   x_max,
  output logic [Y_W-1:0]   y_min,
  output logic [Y_W-1:0]   y_max,
  output logic [CNT_W-1:0] pix_count,
  output logic             bbox_valid,
  output logic             frame_done
);
  import skin_pkg::*;
  logic de_fall;
  logic vsync_rise;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic [X_W-1:0] ax_min;
  logic [X_W-1:0] ax_max;
  logic [Y_W-1:0] ay_min;
  logic [Y_W-1:0] ay_max;
  logic [CNT_W-1:0] acnt;
  state_t state;
  logic skin;
  logic unused;
  assign unused = ^{hsync_in, skin_in[6:0]};
  sync_edge_detect u_edge (
    .clk(clk),
    .rst_n(rst_n),
    .ce(ce),
    .de(de_in),
    .vsync(vsync_in),
    .de_fall(de_fall),
    .vsync_rise(vsync_rise)
  );
  assign skin = ce & de_in & skin_in[7] & (state == ACTIVE);
  // pixel coordinates: x walks the active line, y counts completed lines
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (ce) begin
      x <= (de_fall | vsync_rise) ? '0 : (de_in && x != '1) ? x + 1'b1 : x;
      y <= vsync_rise ? '0 : (de_fall && y != '1) ? y + 1'b1 : y;
    end
  end
  // frame FSM, accumulators and published outputs; REPORT completes even with ce low
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= WAIT_FRAME;
      acnt <= '0;
      ax_min <= '1;
      ax_max <= '0;
      ay_min <= '1;
      ay_max <= '0;
      x_min <= '0;
      x_max <= '0;
      y_min <= '0;
      y_max <= '0;
      pix_count <= '0;
      bbox_valid <= 1'b0;
      frame_done <= 1'b0;
    end else if (state == REPORT) begin
      x_min <= (acnt == '0) ? '0 : ax_min;
      x_max <= (acnt == '0) ? '0 : ax_max;
      y_min <= (acnt == '0) ? '0 : ay_min;
      y_max <= (acnt == '0) ? '0 : ay_max;
      pix_count <= acnt;
      bbox_valid <= 32'(acnt) >= MIN_COUNT;
      frame_done <= 1'b1;
      acnt <= '0;
      ax_min <= '1;
      ax_max <= '0;
      ay_min <= '1;
      ay_max <= '0;
      state <= ACTIVE;
    end else begin
      frame_done <= 1'b0;
      if (skin) begin
        acnt <= (acnt != '1) ? acnt + 1'b1 : acnt;
        ax_min <= (x < ax_min) ? x : ax_min;
        ax_max <= (x > ax_max) ? x : ax_max;
        ay_min <= (y < ay_min) ? y : ay_min;
        ay_max <= (y > ay_max) ? y : ay_max;
      end
      if (vsync_rise) state <= (state == WAIT_FRAME) ? ACTIVE : REPORT;
    end
  end
endmodule

// File: tb/tb_skin_bbox_tracker.sv
// tb_skin_bbox_tracker: scoreboard bench for the skin bbox tracker (default and 4-bit counter builds)
module tb_skin_bbox_tracker;
  import skin_pkg::*;
  typedef struct {
    int xmin;
    int xmax;
    int ymin;
    int ymax;
    int cnt;
    int cnt_s;
    bit valid;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ce = 1'b0;
  logic de_in = 1'b0;
  logic hsync_in = 1'b0;
  logic vsync_in = 1'b0;
  logic [7:0] skin_in = 8'd0;
  logic [10:0] x_min, x_max, xs_min, xs_max;
  logic [9:0] y_min, y_max, ys_min, ys_max;
  logic [20:0] pix_count;
  logic [3:0] pix_count_s;
  logic bbox_valid, frame_done, bbox_valid_s, frame_done_s;
  int checks = 0;
  int failures = 0;
  int fd_count = 0;
  bit fd_prev = 1'b0;
  bit tog = 1'b0;
  exp_t q[$];

  always #5 clk = ~clk;

  skin_bbox_tracker dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .de_in(de_in), .hsync_in(hsync_in),
    .vsync_in(vsync_in), .skin_in(skin_in), .x_min(x_min), .x_max(x_max),
    .y_min(y_min), .y_max(y_max), .pix_count(pix_count), .bbox_valid(bbox_valid),
    .frame_done(frame_done)
  );

  skin_bbox_tracker #(.CNT_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .ce(ce), .de_in(de_in), .hsync_in(hsync_in),
    .vsync_in(vsync_in), .skin_in(skin_in), .x_min(xs_min), .x_max(xs_max),
    .y_min(ys_min), .y_max(ys_max), .pix_count(pix_count_s), .bbox_valid(bbox_valid_s),
    .frame_done(frame_done_s)
  );

  always @(negedge clk) begin
    if (frame_done) begin
      exp_t e;
      fd_count++;
      checks++;
      if (fd_prev) begin
        failures++;
        $display("FAIL frame_done_width got=2+ clks want=1");
      end
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_frame_done got=1 want=0");
      end else begin
        e = q.pop_front();
        checks += 8;
        if (x_min !== e.xmin) begin failures++; $display("FAIL x_min got=%0d want=%0d", x_min, e.xmin); end
        if (x_max !== e.xmax) begin failures++; $display("FAIL x_max got=%0d want=%0d", x_max, e.xmax); end
        if (y_min !== e.ymin) begin failures++; $display("FAIL y_min got=%0d want=%0d", y_min, e.ymin); end
        if (y_max !== e.ymax) begin failures++; $display("FAIL y_max got=%0d want=%0d", y_max, e.ymax); end
        if (pix_count !== e.cnt) begin failures++; $display("FAIL pix_count got=%0d want=%0d", pix_count, e.cnt); end
        if (bbox_valid !== e.valid) begin failures++; $display("FAIL bbox_valid got=%0b want=%0b", bbox_valid, e.valid); end
        if (pix_count_s !== e.cnt_s) begin failures++; $display("FAIL pix_count_sat got=%0d want=%0d", pix_count_s, e.cnt_s); end
        if (frame_done_s !== 1'b1) begin failures++; $display("FAIL frame_done_small got=%0b want=1", frame_done_s); end
      end
    end
    fd_prev = frame_done;
  end

  task automatic step(input logic d, input logic v, input logic [7:0] s);
    de_in = d;
    hsync_in = ~d;
    vsync_in = v;
    skin_in = s;
    ce = 1'b1;
    @(posedge clk);
    #1;
    if (tog) begin
      ce = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  function automatic bit is_skin(input int m, input int xx, input int yy);
    return m == 1 || (m == 0 && xx >= 2 && xx <= 4 && yy >= 1 && yy <= 3) || (m == 3 && yy == 0 && xx < 20);
  endfunction

  task automatic vsync_pulse();
    step(0, 1, 8'd0);
    step(0, 1, 8'd0);
    repeat (3) step(0, 0, 8'd0);
  endtask

  task automatic send_frame(input int w, input int h, input int m, input bit tail);
    exp_t e;
    int lw;
    bit sk;
    e.xmin = 1 << 30; e.xmax = 0; e.ymin = 1 << 30; e.ymax = 0; e.cnt = 0;
    for (int yy = 0; yy < h; yy++) begin
      lw = (tail && yy == h - 1) ? 5 : w;
      for (int xx = 0; xx < lw; xx++) begin
        sk = is_skin(m, xx, yy);
        if (sk) begin
          e.cnt++;
          if (xx < e.xmin) e.xmin = xx;
          if (xx > e.xmax) e.xmax = xx;
          if (yy < e.ymin) e.ymin = yy;
          if (yy > e.ymax) e.ymax = yy;
        end
        step(1, 0, sk ? SKIN_ON : 8'd0);
      end
      if (!(tail && yy == h - 1)) repeat (3) step(0, 0, 8'd0);
    end
    if (tail) begin
      e.cnt++;
      if (5 > e.xmax) e.xmax = 5;
      if (h - 1 > e.ymax) e.ymax = h - 1;
      if (5 < e.xmin) e.xmin = 5;
      if (h - 1 < e.ymin) e.ymin = h - 1;
    end
    if (e.cnt == 0) begin e.xmin = 0; e.xmax = 0; e.ymin = 0; e.ymax = 0; end
    e.cnt_s = e.cnt > 15 ? 15 : e.cnt;
    e.valid = e.cnt >= 64;
    q.push_back(e);
    if (tail) begin
      step(1, 1, SKIN_ON);
      step(0, 1, 8'd0);
      repeat (3) step(0, 0, 8'd0);
    end else vsync_pulse();
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL %s_report_timeout pending=%0d want=0", name, q.size());
      q.delete();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) step(i[0], 0, SKIN_ON);
    checks += 2;
    if ({x_min, x_max, y_min, y_max, pix_count, bbox_valid, frame_done} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%0d/%0d/%0d/%0d/%0d/%0b/%0b want=0", x_min, x_max, y_min, y_max, pix_count, bbox_valid, frame_done);
    end
    if ({xs_min, xs_max, ys_min, ys_max, pix_count_s, bbox_valid_s, frame_done_s} !== '0) begin
      failures++;
      $display("FAIL reset_outputs_small got=%0d/%0d want=0", pix_count_s, xs_max);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    int base;
    do_reset();
    base = fd_count;
    vsync_pulse();
    checks++;
    if (fd_count !== base) begin failures++; $display("FAIL first_vsync_report got=%0d want=%0d", fd_count, base); end
    send_frame(8, 6, 0, 0);
    wait_drain("reset_first");
    repeat (3) for (int xx = 0; xx < 8; xx++) step(1, 0, SKIN_ON);
    do_reset();
    base = fd_count;
    vsync_pulse();
    checks++;
    if (fd_count !== base) begin failures++; $display("FAIL post_reset_vsync_report got=%0d want=%0d", fd_count, base); end
    send_frame(8, 6, 0, 0);
    wait_drain("reset_second");
  endtask

  task automatic test_rect();
    send_frame(8, 6, 0, 0);
    wait_drain("rect");
    repeat (10) step(0, 0, 8'd0);
    checks++;
    if ({x_min, x_max, y_min, y_max, pix_count} !== {11'd2, 11'd4, 10'd1, 10'd3, 21'd9}) begin
      failures++;
      $display("FAIL rect_hold got=%0d,%0d,%0d,%0d,%0d want=2,4,1,3,9", x_min, x_max, y_min, y_max, pix_count);
    end
  endtask

  task automatic test_full();
    send_frame(640, 40, 1, 0);
    wait_drain("full");
  endtask

  task automatic test_empty();
    send_frame(16, 8, 2, 0);
    wait_drain("empty");
  endtask

  task automatic test_ce_toggle();
    tog = 1'b1;
    send_frame(8, 6, 0, 0);
    wait_drain("ce_rect");
    send_frame(8, 4, 0, 1);
    tog = 1'b0;
    wait_drain("ce_tail");
  endtask

  task automatic test_saturate();
    do_reset();
    vsync_pulse();
    send_frame(24, 2, 3, 0);
    wait_drain("sat_20");
    send_frame(8, 6, 0, 0);
    wait_drain("sat_restart");
  endtask

  initial begin
    #2;
    test_reset();
    test_rect();
    test_full();
    test_empty();
    test_ce_toggle();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
endmodule
